// File: rtl/ctrl_mem_read.sv
// Read-side controller for the local data memory: streams rd_len words from
// start_addr onto an AXI-stream master, hiding the 1-cycle read latency.
module ctrl_mem_read #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   rd_len,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   MAX_LEN   = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [ADDR_W-1:0]   addr_cnt;
    logic [ADDR_W:0]     issue_cnt;
    logic [ADDR_W:0]     beat_cnt;
    logic                pending;
    logic [1:0]          buf_count;
    logic [1:0]          wr_ptr;
    logic [1:0]          rd_ptr;
    logic [DATA_W-1:0]   fifo_q [3];
    logic [2:0]          occupancy;
    logic                start_ok;
    logic                pop;

    // Stream handshake: a beat transfers on a rising edge where m_valid and
    // m_ready are both high; m_data/m_last hold while m_valid waits for m_ready.
    always_comb begin
        state_next = state;
        start_ok   = start && (rd_len != '0) && (rd_len <= MAX_LEN);
        occupancy  = {1'b0, buf_count} + {2'b00, pending};
        m_valid    = (buf_count != 2'd0);
        pop        = m_valid && m_ready;
        m_last     = m_valid && (beat_cnt == (ADDR_W + 1)'(1));
        m_data     = m_valid ? fifo_q[rd_ptr] : '0;
        busy       = (state != S_IDLE);
        done       = (state == S_DONE);
        // Issue depends only on registered state, never on m_ready.
        mem_rd_en  = (state == S_RUN) && (issue_cnt != '0) && (occupancy < 3'd3);
        mem_addr   = addr_cnt;

        case (state)
            S_IDLE:  if (start_ok) state_next = S_RUN;
            S_RUN:   if (pop && m_last) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            addr_cnt  <= '0;
            issue_cnt <= '0;
            beat_cnt  <= '0;
            pending   <= 1'b0;
            buf_count <= 2'd0;
            wr_ptr    <= 2'd0;
            rd_ptr    <= 2'd0;
        end else begin
            state   <= state_next;
            pending <= mem_rd_en;

            if (state == S_IDLE && start_ok) begin
                addr_cnt  <= start_addr;
                issue_cnt <= rd_len;
                beat_cnt  <= rd_len;
            end else if (mem_rd_en) begin
                addr_cnt  <= (addr_cnt == LAST_ADDR) ? '0 : addr_cnt + 1'b1;
                issue_cnt <= issue_cnt - 1'b1;
            end

            if (pending) begin
                wr_ptr <= (wr_ptr == 2'd2) ? 2'd0 : wr_ptr + 2'd1;
            end

            if (pop) begin
                rd_ptr   <= (rd_ptr == 2'd2) ? 2'd0 : rd_ptr + 2'd1;
                beat_cnt <= beat_cnt - 1'b1;
            end

            case ({pending, pop})
                2'b10:   buf_count <= buf_count + 2'd1;
                2'b01:   buf_count <= buf_count - 2'd1;
                default: buf_count <= buf_count;
            endcase
        end
    end

    // Data storage needs no reset: buf_count decides what is valid.
    always_ff @(posedge clk) begin
        if (pending) begin
            fifo_q[wr_ptr] <= mem_rd_data;
        end
    end

endmodule

// File: doc/ctrl_mem_read.md
Name: ctrl_mem_read

Overview:
- Read-side controller for the 16-entry local data memory.
- On a start command it streams a programmed number of words out of memory onto an AXI-stream master port, starting at a programmed address.
- It hides the 1-cycle synchronous memory read latency behind a 3-entry output buffer, so it sustains 1 beat/cycle under continuous m_ready.
- It sits between the data memory and the downstream consumer (next layer or host).

Parameters:
- DEPTH, 16, number of memory words; addresses wrap at DEPTH-1.
- ADDR_W, 4, memory address width, equal to log2(DEPTH).
- DATA_W, 16, memory word and stream data width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a transfer; sampled only in IDLE.
- start_addr  input  ADDR_W  first memory address of the transfer.
- rd_len  input  ADDR_W+1  number of words to transfer, 1..DEPTH.
- mem_addr  output  ADDR_W  memory read address.
- mem_rd_en  output  1  memory read enable.
- mem_rd_data  input  DATA_W  memory read data, valid the cycle after mem_rd_en is high.
- m_data  output  DATA_W  stream data.
- m_valid  output  1  stream valid.
- m_ready  input  1  stream ready from the consumer.
- m_last  output  1  marks the final beat of the transfer.
- busy  output  1  high while a transfer is in progress (not IDLE).
- done  output  1  one-cycle pulse after the final beat is accepted.

Behaviour:
- Reset (reset=0, async), all forced to 0:
  - state=IDLE;
  - mem_addr, mem_rd_en, m_valid, m_last, busy, done;
  - buffer count, pending flag, issue and beat counters.
  - A reset asserted mid-transfer aborts the transfer silently: no done, buffered data discarded.
- FSM states:
  - IDLE -> RUN on start=1 with rd_len in 1..DEPTH. Latch start_addr into the address counter, rd_len into the issue and beat counters; busy=1 from the next cycle.
  - start with rd_len=0 or rd_len>DEPTH is ignored and the FSM stays in IDLE.
  - start while busy is ignored.
  - RUN -> DONE when the final beat handshakes (m_valid & m_ready & m_last).
  - DONE -> IDLE unconditionally after 1 cycle; done=1 and busy=1 during DONE.
- Read issue (RUN only):
  - mem_rd_en=1 when issue counter>0 and (buf_count + pending) < 3. pending=1 when a read was issued in the previous cycle.
  - This condition has no combinational path from m_ready.
  - On issue: mem_addr advances by 1 for the next read; it wraps from DEPTH-1 to 0; issue counter decrements.
  - mem_addr holds its value when not issuing.
- Capture: when pending=1, mem_rd_data is written into the 3-entry FIFO at the end of that cycle.
- Output:
  - m_valid = (buf_count>0); m_data = FIFO head.
  - Pop on m_valid & m_ready.
  - Once m_valid is high, m_data and m_valid stay stable until the handshake.
  - Simultaneous capture and pop in the same cycle keeps buf_count unchanged.
- m_last = m_valid & (beat counter==1). Beat counter decrements on each handshake.
- Latency (start sampled at edge E0, m_ready=1):
  - mem_rd_en high in cycle 1;
  - data captured at end of cycle 2;
  - m_valid first high in cycle 3;
  - then 1 beat/cycle; done high the cycle after the last handshake.
- Backpressure: m_ready=0 stalls reads after the FIFO fills. At most 3 words are buffered and no data is lost or duplicated.
- Word ordering: beats leave in address order start_addr, start_addr+1, ... modulo DEPTH.

Test Plan:
- Reset, then start with start_addr=0 and rd_len=16, m_ready=1 tied high; memory holds mem[i]=i+100. Required: m_valid first high 3 cycles after start; beats 100..115 on consecutive cycles; m_last only on 115; done pulse 1 cycle later; busy low afterwards.
- Wrap-around: start_addr=14, rd_len=4. Required: mem_addr sequence 14,15,0,1; data mem[14],mem[15],mem[0],mem[1]; m_last on the 4th beat.
- Backpressure: rd_len=8, m_ready toggling 1,0,0,1,0,1,... Required: exactly 8 beats in order; m_data stable across stalled cycles; mem_rd_en never high while buf_count+pending=3.
- Illegal and ignored starts: start with rd_len=0 -> busy stays 0, no mem_rd_en. start pulsed again mid-transfer -> ignored; the original transfer completes unchanged.
- Reset mid-transfer: assert reset after 3 of 10 beats. Required: all outputs 0 immediately with no done. A new start(addr=5, len=2) afterwards yields mem[5], mem[6].
- Single word: rd_len=1 with m_ready=0 for 5 cycles, then 1. Required: m_valid and m_last held high with mem[start_addr]; one handshake; done pulse the following cycle.
